// File: rtl/rv32i_types.sv
// Shared RV32I types: load/store funct3 encodings and the memory arbiter's
// state, owner and latched-request definitions.
package rv32i_types;

  localparam int XLEN = 32;
  localparam logic [3:0] MASK_FULL = 4'b1111;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } load_f3_t;

  typedef enum logic [2:0] {
    ST_B = 3'b000,
    ST_H = 3'b001,
    ST_W = 3'b010
  } store_f3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mem_arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } mem_owner_t;

  typedef struct packed {
    mem_owner_t       owner;
    logic             we;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane alignment for RV32I loads/stores: masks, positioned store data,
// extended load data and the misaligned/illegal-funct3 flag.
module mem_lsu_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  o,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  rmask,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        illegal
);

  logic [4:0]  sh;
  logic [31:0] rshift;
  logic [3:0]  mask;

  assign sh     = {o, 3'b000};
  assign rshift = rdata >> sh;

  always_comb begin
    mask       = '0;
    illegal    = 1'b0;
    wdata_lane = '0;
    rdata_ext  = '0;
    case (funct3)
      LD_B: begin
        mask       = 4'b0001 << o;
        wdata_lane = {24'b0, wdata[7:0]} << sh;
        rdata_ext  = {{24{rshift[7]}}, rshift[7:0]};
      end
      LD_H: begin
        mask       = 4'b0011 << o;
        illegal    = o[0];
        wdata_lane = {16'b0, wdata[15:0]} << sh;
        rdata_ext  = {{16{rshift[15]}}, rshift[15:0]};
      end
      LD_W: begin
        mask       = MASK_FULL;
        illegal    = (o != 2'b00);
        wdata_lane = wdata;
        rdata_ext  = rdata;
      end
      // unsigned variants exist only for loads
      LD_BU: begin
        mask      = 4'b0001 << o;
        illegal   = we;
        rdata_ext = {24'b0, rshift[7:0]};
      end
      LD_HU: begin
        mask      = 4'b0011 << o;
        illegal   = we | o[0];
        rdata_ext = {16'b0, rshift[15:0]};
      end
      default: illegal = 1'b1;
    endcase
    if (!we || illegal) wdata_lane = '0;
    rmask = (we || illegal) ? 4'b0000 : mask;
    wmask = (we && !illegal) ? mask : 4'b0000;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store, one access at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of data-over-fetch.
//
// state | meaning
// IDLE  | no access outstanding; arbitrate between eligible requesters
// WAIT  | memory outputs driven from the latched request until mem_resp
// ERR   | misaligned/illegal data request; dmem_resp+dmem_err high this cycle
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              imem_req,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_rdata,
  output logic              imem_resp,
  input  logic              dmem_req,
  input  logic              dmem_we,
  input  logic [2:0]        dmem_funct3,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [31:0]       dmem_wdata,
  output logic [31:0]       dmem_rdata,
  output logic              dmem_resp,
  output logic              dmem_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_rmask,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_resp
);

  mem_arb_state_t state;
  mem_req_t       req;

  logic        data_elig, fetch_elig, grant_data, grant_fetch;
  logic        in_idle, in_wait, data_owned;
  logic [2:0]  al_f3;
  logic [1:0]  al_o;
  logic        al_we;
  logic [31:0] al_wdata;
  logic [3:0]  al_rmask, al_wmask;
  logic [31:0] al_wdata_lane, al_rdata_ext;
  logic        al_illegal;

`ifdef MEM_ARB_RR_EN
  mem_owner_t last_grant;
`endif

  assign in_idle    = (state == IDLE);
  assign in_wait    = (state == WAIT);
  assign data_owned = (req.owner == OWN_DATA);

  // a requester whose response is showing this cycle is not re-sampled
  assign data_elig  = dmem_req && !dmem_resp;
  assign fetch_elig = imem_req && !imem_resp;

`ifdef MEM_ARB_RR_EN
  assign grant_data = data_elig && (!fetch_elig || (last_grant == OWN_FETCH));
`else
  assign grant_data = data_elig;
`endif
  assign grant_fetch = fetch_elig && !grant_data;

  // IDLE checks the live request; WAIT formats against the latched one
  assign al_f3    = in_idle ? dmem_funct3     : req.funct3;
  assign al_o     = in_idle ? dmem_addr[1:0]  : req.addr[1:0];
  assign al_we    = in_idle ? dmem_we         : req.we;
  assign al_wdata = in_idle ? dmem_wdata      : req.wdata;

  mem_lsu_align u_align (
    .funct3     (al_f3),
    .o          (al_o),
    .we         (al_we),
    .wdata      (al_wdata),
    .rdata      (mem_rdata),
    .rmask      (al_rmask),
    .wmask      (al_wmask),
    .wdata_lane (al_wdata_lane),
    .rdata_ext  (al_rdata_ext),
    .illegal    (al_illegal)
  );

  assign mem_addr  = in_wait ? {req.addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_rmask = !in_wait ? 4'b0000 : (data_owned ? al_rmask : MASK_FULL);
  assign mem_wmask = (in_wait && data_owned) ? al_wmask : 4'b0000;
  assign mem_wdata = (in_wait && data_owned) ? al_wdata_lane : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req        <= '0;
      imem_rdata <= '0;
      imem_resp  <= 1'b0;
      dmem_rdata <= '0;
      dmem_resp  <= 1'b0;
      dmem_err   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant <= OWN_FETCH;
`endif
    end else begin
      imem_resp  <= 1'b0;
      imem_rdata <= '0;
      dmem_resp  <= 1'b0;
      dmem_rdata <= '0;
      dmem_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_data) begin
            req <= '{owner: OWN_DATA, we: dmem_we, funct3: dmem_funct3,
                     addr: dmem_addr, wdata: dmem_wdata};
`ifdef MEM_ARB_RR_EN
            last_grant <= OWN_DATA;
`endif
            if (al_illegal) begin
              state     <= ERR;
              dmem_resp <= 1'b1;
              dmem_err  <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end else if (grant_fetch) begin
            req <= '{owner: OWN_FETCH, we: 1'b0, funct3: LD_W,
                     addr: imem_addr, wdata: '0};
`ifdef MEM_ARB_RR_EN
            last_grant <= OWN_FETCH;
`endif
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp) begin
            state <= IDLE;
            if (data_owned) begin
              dmem_resp  <= 1'b1;
              dmem_rdata <= req.we ? 32'h0 : al_rdata_ext;
            end else begin
              imem_resp  <= 1'b1;
              imem_rdata <= mem_rdata;
            end
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed and randomized load/store,
// fetch, arbitration order and asynchronous reset against a byte-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        dmem_req;
  logic        dmem_we;
  logic [2:0]  dmem_funct3;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        dmem_err;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int n_cmp = 0;
  int n_bad = 0;
  bit mdl_last_data = 1'b0;

  logic [138:0] all_out;
  assign all_out = {imem_rdata, imem_resp, dmem_rdata, dmem_resp, dmem_err,
                    mem_addr, mem_rmask, mem_wmask, mem_wdata};

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_funct3(dmem_funct3), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .dmem_err(dmem_err),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: access size/signedness from funct3, byte-by-byte lane placement.
  function automatic void ref_access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                     input logic [31:0] wd, input logic [31:0] rw,
                                     output bit err, output logic [3:0] rm, output logic [3:0] wm,
                                     output logic [31:0] mwd, output logic [31:0] rd);
    int size;
    bit uns;
    int o;
    o = int'(addr[1:0]);
    size = 0;
    uns = 1'b0;
    if (f3 == 3'd0) size = 1;
    else if (f3 == 3'd1) size = 2;
    else if (f3 == 3'd2) size = 4;
    else if (!we && f3 == 3'd4) begin size = 1; uns = 1'b1; end
    else if (!we && f3 == 3'd5) begin size = 2; uns = 1'b1; end
    if (size == 0) err = 1'b1;
    else err = (o % size) != 0;
    rm = '0; wm = '0; mwd = '0; rd = '0;
    if (!err) begin
      for (int i = 0; i < size; i++) begin
        if (we) begin
          wm[o+i] = 1'b1;
          mwd[8*(o+i) +: 8] = wd[8*i +: 8];
        end else begin
          rm[o+i] = 1'b1;
          rd[8*i +: 8] = rw[8*(o+i) +: 8];
        end
      end
      if (!we && !uns && size < 4 && rd[8*size-1])
        for (int i = size; i < 4; i++) rd[8*i +: 8] = 8'hFF;
    end
  endfunction

  // Drives one data request and plays a memory with the given latency.
  task automatic run_data(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rw, input int lat,
                          output bit acc, output logic [31:0] o_addr, output logic [3:0] o_rm,
                          output logic [3:0] o_wm, output logic [31:0] o_wd,
                          output logic [31:0] o_rd, output bit o_err, output int cyc);
    int waited;
    acc = 1'b0; o_addr = '0; o_rm = '0; o_wm = '0; o_wd = '0; o_rd = '0; o_err = 1'b0;
    cyc = -1; waited = 0;
    @(negedge clk);
    dmem_req = 1'b1; dmem_we = we; dmem_funct3 = f3; dmem_addr = addr; dmem_wdata = wd;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      mem_resp = 1'b0;
      if (dmem_resp) begin
        o_rd = dmem_rdata; o_err = dmem_err; cyc = i;
        break;
      end
      if ((mem_rmask | mem_wmask) != 4'b0) begin
        if (!acc) begin
          acc = 1'b1; o_addr = mem_addr; o_rm = mem_rmask; o_wm = mem_wmask; o_wd = mem_wdata;
        end
        if (waited == lat) begin mem_resp = 1'b1; mem_rdata = rw; end
        waited++;
      end
    end
    dmem_req = 1'b0;
    mem_resp = 1'b0;
    mdl_last_data = 1'b1;
  endtask

  task automatic run_fetch(input logic [31:0] addr, input logic [31:0] rw, input int lat,
                           output bit acc, output logic [31:0] o_addr, output logic [3:0] o_rm,
                           output logic [3:0] o_wm, output logic [31:0] o_rd, output int cyc);
    int waited;
    acc = 1'b0; o_addr = '0; o_rm = '0; o_wm = '0; o_rd = '0; cyc = -1; waited = 0;
    @(negedge clk);
    imem_req = 1'b1; imem_addr = addr;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      mem_resp = 1'b0;
      if (imem_resp) begin o_rd = imem_rdata; cyc = i; break; end
      if ((mem_rmask | mem_wmask) != 4'b0) begin
        if (!acc) begin acc = 1'b1; o_addr = mem_addr; o_rm = mem_rmask; o_wm = mem_wmask; end
        if (waited == lat) begin mem_resp = 1'b1; mem_rdata = rw; end
        waited++;
      end
    end
    imem_req = 1'b0;
    mem_resp = 1'b0;
    mdl_last_data = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mdl_last_data = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++; $display("FAIL idle_outputs: got %h want 0", all_out);
    end
  endtask

  task automatic test_spurious_resp();
    int hits;
    hits = 0;
    mem_resp = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (imem_resp || dmem_resp || mem_rmask != 0 || mem_wmask != 0) hits++;
      @(negedge clk);
    end
    n_cmp++;
    if (hits !== 0) begin n_bad++; $display("FAIL spurious_mem_resp: got %0d activity cycles want 0", hits); end
  endtask

  task automatic test_fetch();
    bit acc; logic [31:0] a, rd; logic [3:0] rm, wm; int cyc, extra;
    run_fetch(32'h0000_1004, 32'h0051_3093, 3, acc, a, rm, wm, rd, cyc);
    n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL fetch_access: got %0d want 1", acc); end
    n_cmp++; if (a !== 32'h1004) begin n_bad++; $display("FAIL fetch_addr: got %h want 00001004", a); end
    n_cmp++; if ({rm, wm} !== 8'hF0) begin n_bad++; $display("FAIL fetch_masks: got %b/%b want 1111/0000", rm, wm); end
    n_cmp++; if (rd !== 32'h0051_3093) begin n_bad++; $display("FAIL fetch_rdata: got %h want 00513093", rd); end
    n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL fetch_latency: got %0d want 5", cyc); end
    extra = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (imem_resp) extra++; end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL fetch_single_pulse: got %0d extra want 0", extra); end
  endtask

  typedef struct {
    bit we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wd; logic [31:0] rw;
    bit err; logic [3:0] rm; logic [3:0] wm; logic [31:0] mwd; logic [31:0] rd;
  } dir_t;

  task automatic test_lsu_directed();
    dir_t tbl[5];
    bit acc, err; logic [31:0] a, wdo, rd; logic [3:0] rm, wm; int cyc, elat;
    tbl[0] = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 1'b0, 4'b1000, 4'b0000, 32'h0, 32'hFFFF_FF80};
    tbl[1] = '{1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 1'b0, 4'b1000, 4'b0000, 32'h0, 32'h0000_0080};
    tbl[2] = '{1'b1, 3'b001, 32'h202, 32'hDEAD_BEEF, 32'h0, 1'b0, 4'b0000, 4'b1100, 32'hBEEF_0000, 32'h0};
    tbl[3] = '{1'b0, 3'b010, 32'h201, 32'h0, 32'h1234_5678, 1'b1, 4'b0000, 4'b0000, 32'h0, 32'h0};
    tbl[4] = '{1'b1, 3'b011, 32'h300, 32'hCAFE_F00D, 32'h0, 1'b1, 4'b0000, 4'b0000, 32'h0, 32'h0};
    for (int k = 0; k < 5; k++) begin
      run_data(tbl[k].we, tbl[k].f3, tbl[k].addr, tbl[k].wd, tbl[k].rw, 1,
               acc, a, rm, wm, wdo, rd, err, cyc);
      elat = tbl[k].err ? 1 : 3;
      n_cmp++; if (err !== tbl[k].err) begin n_bad++; $display("FAIL dir%0d_err: got %0d want %0d", k, err, tbl[k].err); end
      n_cmp++; if (cyc !== elat) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", k, cyc, elat); end
      n_cmp++; if (acc !== !tbl[k].err) begin n_bad++; $display("FAIL dir%0d_access: got %0d want %0d", k, acc, !tbl[k].err); end
      n_cmp++; if (a !== (tbl[k].err ? 32'h0 : {tbl[k].addr[31:2], 2'b00})) begin n_bad++; $display("FAIL dir%0d_addr: got %h", k, a); end
      n_cmp++; if ({rm, wm, wdo} !== {tbl[k].rm, tbl[k].wm, tbl[k].mwd}) begin
        n_bad++; $display("FAIL dir%0d_lanes: got %b/%b/%h want %b/%b/%h", k, rm, wm, wdo, tbl[k].rm, tbl[k].wm, tbl[k].mwd);
      end
      n_cmp++; if (rd !== tbl[k].rd) begin n_bad++; $display("FAIL dir%0d_rdata: got %h want %h", k, rd, tbl[k].rd); end
    end
  endtask

  task automatic test_random_lsu();
    bit we, acc, err, x_err; logic [2:0] f3; logic [31:0] addr, wd, rw, a, wdo, rd, x_wd, x_rd;
    logic [3:0] rm, wm, x_rm, x_wm; int lat, cyc, x_lat;
    for (int k = 0; k < 60; k++) begin
      we = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
      addr = $urandom; wd = $urandom; rw = $urandom; lat = int'($urandom_range(0, 3));
      ref_access(we, f3, addr, wd, rw, x_err, x_rm, x_wm, x_wd, x_rd);
      run_data(we, f3, addr, wd, rw, lat, acc, a, rm, wm, wdo, rd, err, cyc);
      x_lat = x_err ? 1 : lat + 2;
      n_cmp++; if ({err, acc} !== {x_err, !x_err}) begin
        n_bad++; $display("FAIL rnd%0d_err: got err=%0d acc=%0d want err=%0d (we=%0d f3=%0d a=%h)", k, err, acc, x_err, we, f3, addr);
      end
      n_cmp++; if (cyc !== x_lat) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", k, cyc, x_lat); end
      n_cmp++; if ({rm, wm, wdo} !== {x_rm, x_wm, x_wd}) begin
        n_bad++; $display("FAIL rnd%0d_lanes: got %b/%b/%h want %b/%b/%h", k, rm, wm, wdo, x_rm, x_wm, x_wd);
      end
      n_cmp++; if (rd !== x_rd) begin n_bad++; $display("FAIL rnd%0d_rdata: got %h want %h (f3=%0d a=%h rw=%h)", k, rd, x_rd, f3, addr, rw); end
      if (!x_err) begin
        n_cmp++; if (a !== {addr[31:2], 2'b00}) begin n_bad++; $display("FAIL rnd%0d_addr: got %h want %h", k, a, {addr[31:2], 2'b00}); end
      end
    end
  endtask

  // Both requesters issue 4 requests each, re-raising as soon as served.
  task automatic test_back_to_back();
    bit acc, err; logic [31:0] a, wdo, rd; logic [3:0] rm, wm; int cyc;
    bit order[8]; int n_done, d_left, f_left; bit exp_first, exp_o;
    logic [31:0] d_addr, f_addr;
    run_data(1'b0, 3'b010, 32'h400, 32'h0, 32'h1111_2222, 0, acc, a, rm, wm, wdo, rd, err, cyc);
`ifdef MEM_ARB_RR_EN
    exp_first = !mdl_last_data;
`else
    exp_first = 1'b1;
`endif
    n_done = 0; d_left = 4; f_left = 4;
    d_addr = 32'h0000_0800; f_addr = 32'h0000_2000;
    @(negedge clk);
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_funct3 = 3'b010; dmem_addr = d_addr; dmem_wdata = '0;
    imem_req = 1'b1; imem_addr = f_addr;
    for (int i = 0; i < 200 && n_done < 8; i++) begin
      @(negedge clk);
      mem_resp = 1'b0;
      if (dmem_resp) begin
        order[n_done] = 1'b1; n_done++; d_left--;
        n_cmp++; if (dmem_rdata !== (d_addr ^ 32'hA5A5_0000)) begin n_bad++; $display("FAIL b2b_drdata: got %h want %h", dmem_rdata, d_addr ^ 32'hA5A5_0000); end
        d_addr += 4;
        if (d_left > 0) dmem_addr = d_addr; else dmem_req = 1'b0;
      end
      if (imem_resp) begin
        order[n_done] = 1'b0; n_done++; f_left--;
        n_cmp++; if (imem_rdata !== (f_addr ^ 32'hA5A5_0000)) begin n_bad++; $display("FAIL b2b_irdata: got %h want %h", imem_rdata, f_addr ^ 32'hA5A5_0000); end
        f_addr += 4;
        if (f_left > 0) imem_addr = f_addr; else imem_req = 1'b0;
      end
      if (mem_rmask != 4'b0) begin mem_resp = 1'b1; mem_rdata = mem_addr ^ 32'hA5A5_0000; end
    end
    dmem_req = 1'b0; imem_req = 1'b0; mem_resp = 1'b0;
    n_cmp++; if (n_done !== 8) begin n_bad++; $display("FAIL b2b_count: got %0d want 8", n_done); end
    for (int k = 0; k < n_done; k++) begin
      exp_o = (k % 2 == 0) ? exp_first : !exp_first;
      n_cmp++; if (order[k] !== exp_o) begin n_bad++; $display("FAIL b2b_order%0d: got owner %0d want %0d", k, order[k], exp_o); end
    end
    if (n_done > 0) mdl_last_data = order[n_done-1];
  endtask

  task automatic test_reset_mid();
    bit seen, got; logic [31:0] a, rd;
    seen = 1'b0; got = 1'b0; a = '0; rd = '0;
    @(negedge clk);
    imem_req = 1'b1; imem_addr = 32'h0000_3008;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (mem_rmask != 4'b0) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rst_mid_wait: got %0d want 1", seen); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL rst_mid_async: got %h want 0", all_out); end
    @(negedge clk);
    rst_n = 1'b1;
    mdl_last_data = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      mem_resp = 1'b0;
      if (imem_resp) begin got = 1'b1; rd = imem_rdata; end
      else if (mem_rmask != 4'b0 && !seen) begin
        seen = 1'b1; a = mem_addr; mem_resp = 1'b1; mem_rdata = 32'h0000_0013;
      end
    end
    imem_req = 1'b0; mem_resp = 1'b0;
    n_cmp++; if (a !== 32'h3008) begin n_bad++; $display("FAIL rst_reissue_addr: got %h want 00003008", a); end
    n_cmp++; if ({got, rd} !== {1'b1, 32'h0000_0013}) begin n_bad++; $display("FAIL rst_reissue_resp: got %0d/%h want 1/00000013", got, rd); end
  endtask

  initial begin
    imem_req = 1'b0; imem_addr = '0;
    dmem_req = 1'b0; dmem_we = 1'b0; dmem_funct3 = '0; dmem_addr = '0; dmem_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    test_reset();
    test_spurious_resp();
    test_fetch();
    test_lsu_directed();
    test_random_lsu();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one 32-bit memory port between the instruction-fetch requester and the load/store requester of the RV32I core.
- Serialises requests one at a time.
- Generates byte masks and aligned write data from load/store funct3.
- Aligns, sign-extends or zero-extends load data.
- Flags misaligned or illegal data accesses without touching memory.

Parameters:
- ADDR_W, 32, address width of requesters and memory port.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- imem_req  in  1  fetch request; held with imem_addr stable until imem_resp.
- imem_addr  in  ADDR_W  fetch address; bits [1:0] ignored.
- imem_rdata  out  32  fetched word; valid only while imem_resp=1.
- imem_resp  out  1  one-cycle completion pulse.
- dmem_req  in  1  data request; held with all dmem_* inputs stable until dmem_resp.
- dmem_we  in  1  1=store, 0=load.
- dmem_funct3  in  3  load_f3_t / store_f3_t encoding.
- dmem_addr  in  ADDR_W  byte address.
- dmem_wdata  in  32  store data, LSB-justified.
- dmem_rdata  out  32  extended load result; valid while dmem_resp=1.
- dmem_resp  out  1  one-cycle completion pulse.
- dmem_err  out  1  with dmem_resp: misaligned or illegal funct3; no memory access made.
- mem_addr  out  ADDR_W  word-aligned address, bits [1:0]=0.
- mem_rmask  out  4  read byte mask.
- mem_wmask  out  4  write byte mask.
- mem_wdata  out  32  byte-lane-positioned write data.
- mem_rdata  in  32  read data; valid with mem_resp.
- mem_resp  in  1  memory completion, one cycle.

Behaviour:
- Reset (async assert) clears all of the following to 0 immediately:
  - all outputs;
  - state goes to IDLE;
  - the last-grant register;
  - the latched request.
- An outstanding memory access is abandoned; memory shares rst_n.
- States: IDLE, WAIT, ERR.
- IDLE:
  - Select among requesters whose req=1 and whose resp is not asserted this cycle.
  - A requester with resp=1 this cycle is not sampled.
  - Arbitration is fixed priority, data over fetch.
  - Latch the winner's fields into the request register.
  - Data winner that is misaligned or has illegal funct3 → ERR. Otherwise → WAIT.
- WAIT:
  - mem_addr, mem_rmask, mem_wmask and mem_wdata are driven from registers, stable every cycle until mem_resp.
  - On mem_resp: register the formatted rdata and assert the owner's resp for exactly the next cycle; state goes to IDLE.
- ERR: next cycle assert dmem_resp=1 and dmem_err=1 with dmem_rdata=0; state goes to IDLE.
- Latency: request seen in IDLE at cycle t → memory outputs valid at t+1 → resp one cycle after mem_resp. Zero-wait memory gives resp at t+2. Error gives resp at t+1.
- Masks with o=addr[1:0]:
  - b/bu: 0001<<o.
  - h/hu: 0011<<o; legal only if o[0]=0.
  - w: 1111; legal only if o=0.
  - Fetch: rmask=1111.
  - Loads: wmask=0. Stores: rmask=0.
- Store data:
  - sb: wdata[7:0]<<8o.
  - sh: wdata[15:0]<<8o.
  - sw: unchanged.
  - Unused lanes are 0.
- Load data: shift mem_rdata right by 8o, then:
  - lb/lh: sign-extend from bit 7/15.
  - lbu/lhu: zero-extend.
  - lw: pass through.
- Illegal funct3:
  - loads: 011, 110, 111;
  - stores: any value ≥011.
- Responses are never asserted in IDLE without a completed or errored transaction.
- mem_resp outside WAIT is ignored.
- Outside WAIT, all memory masks are 0.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration. When both request in IDLE, the requester not granted last wins. The last-grant register updates on every grant; its reset value favours data.
- Undefined: fixed data-over-fetch priority; the last-grant register is absent.

Decomposition:
- Add to the rv32i_types package:
  - mem_arb_state_t enum (IDLE, WAIT, ERR);
  - mem_req_t packed struct (owner, we, funct3, addr, wdata);
  - a constant for the full mask, 4'b1111.
- Natural sub-module: mem_lsu_align, a combinational block taking funct3, o, data and we. It produces:
  - rmask and wmask;
  - shifted wdata;
  - the extended load result;
  - the illegal flag.

Test Plan:
- Fetch only: imem_addr=0x0000_1004, memory responds after 3 cycles with 0x0051_3093 → mem_addr=0x1004, rmask=1111; imem_resp pulses once, imem_rdata=0x0051_3093.
- Both requesters assert in the same IDLE cycle:
  - default build: data served first, fetch immediately after its resp;
  - MEM_ARB_RR_EN build: grants alternate across 4 back-to-back paired requests.
- lb at 0x103 with mem_rdata=0x80FF_1234 → rmask=1000, dmem_rdata=0xFFFF_FF80. lbu at the same address → 0x0000_0080.
- sh at 0x202, wdata=0xDEAD_BEEF → wmask=1100, mem_wdata=0xBEEF_0000, rmask=0.
- Error cases: lw at 0x201 → no memory access, dmem_resp and dmem_err at t+1. Store with funct3=011 → same result.
- Reset handling: rst_n low during WAIT → all outputs 0 asynchronously. After release, a held imem_req is re-issued from IDLE.
